// File: rtl/spi_gpio_expander.sv
// SPI-slave register file for a GPIO port: OUT, DIR, IN and an accepted-frame counter.
// Define SPI_GPIO_READBACK_EN to build read frames and the MISO shifter; otherwise MISO is tied low.
module spi_gpio_expander #(
    parameter int                 g_width    = 8,
    parameter logic [g_width-1:0] g_out_init = '0
) (
    input  logic               clk_sys_i,
    input  logic               rst_n_i,
    input  logic               spi_sclk_i,
    input  logic               spi_cs_n_i,
    input  logic               spi_mosi_i,
    output logic               spi_miso_o,
    input  logic [g_width-1:0] gpio_i,
    output logic [g_width-1:0] gpio_o,
    output logic [g_width-1:0] gpio_oe_o,
    output logic               frame_ok_p_o,
    output logic               frame_err_p_o
);

    localparam int FRAME_BITS = 8 + g_width;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_WAIT,
        ST_ERR
    } state_t;

    logic [1:0]          sclk_sync_reg;
    logic [1:0]          cs_sync_reg;
    logic [1:0]          mosi_sync_reg;
    logic                sclk_d_reg;
    logic                cs_d_reg;
    logic [1:0]          settle_reg;
    logic                cs_armed_reg;
    logic [g_width-1:0]  gpio_meta_reg;
    logic [g_width-1:0]  gpio_sync_reg;

    logic                sclk_rise;
    logic                sclk_fall;
    logic                cs_rise;
    logic                cs_fall;

    state_t              state_reg;
    state_t              state_next;
    logic                commit_ok;
    logic                commit_err;

    logic [CNT_W-1:0]      bit_cnt_reg;
    logic [FRAME_BITS-1:0] rx_reg;
    logic [FRAME_BITS-1:0] rx_next;
    logic                  cmd_done;

    logic                ok_req_reg;
    logic                err_req_reg;
    logic                wr_en_reg;
    logic [6:0]          wr_addr_reg;
    logic [g_width-1:0]  wr_data_reg;

    logic [g_width-1:0]  out_reg;
    logic [g_width-1:0]  dir_reg;
    logic [7:0]          fcnt_reg;
    logic                frame_ok_reg;
    logic                frame_err_reg;

    logic [g_width-1:0]  fcnt_ext;
    logic [g_width-1:0]  rd_data;

    // Input synchronisers. CS stages reset high so reset never looks like a frame start.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sclk_sync_reg <= '0;
            cs_sync_reg   <= 2'b11;
            mosi_sync_reg <= '0;
            sclk_d_reg    <= 1'b0;
            cs_d_reg      <= 1'b1;
            settle_reg    <= '0;
            cs_armed_reg  <= 1'b0;
            gpio_meta_reg <= '0;
            gpio_sync_reg <= '0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[0], spi_sclk_i};
            cs_sync_reg   <= {cs_sync_reg[0], spi_cs_n_i};
            mosi_sync_reg <= {mosi_sync_reg[0], spi_mosi_i};
            sclk_d_reg    <= sclk_sync_reg[1];
            cs_d_reg      <= cs_sync_reg[1];
            settle_reg    <= {settle_reg[0], 1'b1};
            gpio_meta_reg <= gpio_i;
            gpio_sync_reg <= gpio_meta_reg;
            // A frame may only start once CS has been genuinely seen high after reset
            if (settle_reg[1] && cs_sync_reg[1]) begin
                cs_armed_reg <= 1'b1;
            end
        end
    end

    assign sclk_rise = sclk_sync_reg[1] & ~sclk_d_reg;
    assign sclk_fall = ~sclk_sync_reg[1] & sclk_d_reg;
    assign cs_rise   = cs_sync_reg[1] & ~cs_d_reg;
    assign cs_fall   = cs_armed_reg & ~cs_sync_reg[1] & cs_d_reg;

    assign rx_next  = {rx_reg[FRAME_BITS-2:0], mosi_sync_reg[1]};
    assign cmd_done = (state_reg == ST_CMD) && sclk_rise && !cs_rise &&
                      (bit_cnt_reg == CNT_W'(7));

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        commit_ok  = 1'b0;
        commit_err = 1'b0;
        if (cs_rise) begin
            state_next = ST_IDLE;
            commit_ok  = (state_reg == ST_WAIT);
            commit_err = (state_reg == ST_CMD) || (state_reg == ST_DATA) ||
                         (state_reg == ST_ERR);
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_next = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise && bit_cnt_reg == CNT_W'(7)) begin
                        state_next = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sclk_rise && bit_cnt_reg == CNT_W'(FRAME_BITS - 1)) begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sclk_rise) begin
                        state_next = ST_ERR;
                    end
                end
                default: state_next = state_reg;
            endcase
        end
    end

    // Receive shifter: holds the whole frame so the commit sees R/W, address and data together
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_cnt_reg <= '0;
            rx_reg      <= '0;
        end else if (state_reg == ST_IDLE) begin
            bit_cnt_reg <= '0;
            rx_reg      <= '0;
        end else if (sclk_rise && !cs_rise &&
                     (state_reg == ST_CMD || state_reg == ST_DATA)) begin
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            rx_reg      <= rx_next;
        end
    end

    // One pipeline stage between CS-rise detection and the register update keeps
    // the commit a fixed three clocks after CS is first sampled high.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ok_req_reg    <= 1'b0;
            err_req_reg   <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            out_reg       <= g_out_init;
            dir_reg       <= '0;
            fcnt_reg      <= '0;
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            ok_req_reg  <= commit_ok;
            err_req_reg <= commit_err;
            if (commit_ok) begin
                wr_en_reg   <= ~rx_reg[FRAME_BITS-1];
                wr_addr_reg <= rx_reg[FRAME_BITS-2 -: 7];
                wr_data_reg <= rx_reg[g_width-1:0];
            end else begin
                wr_en_reg <= 1'b0;
            end

            frame_ok_reg  <= ok_req_reg;
            frame_err_reg <= err_req_reg;
            if (ok_req_reg) begin
                fcnt_reg <= fcnt_reg + 8'd1;
            end
            if (wr_en_reg && wr_addr_reg == 7'h00) begin
                out_reg <= wr_data_reg;
            end
            if (wr_en_reg && wr_addr_reg == 7'h01) begin
                dir_reg <= wr_data_reg;
            end
        end
    end

    // Read mux addressed by the command byte as it completes
    always_comb begin
        fcnt_ext      = '0;
        fcnt_ext[7:0] = fcnt_reg;
        rd_data       = '0;
        case (rx_next[6:0])
            7'h00:   rd_data = out_reg;
            7'h01:   rd_data = dir_reg;
            7'h02:   rd_data = gpio_sync_reg;
            7'h03:   rd_data = fcnt_ext;
            default: rd_data = '0;
        endcase
    end

`ifdef SPI_GPIO_READBACK_EN
    logic [g_width-1:0] tx_reg;
    logic               miso_reg;

    // Write frames load zeros, so MISO stays low for them without a separate flag
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_reg   <= '0;
            miso_reg <= 1'b0;
        end else if (state_reg == ST_DATA && !cs_rise) begin
            if (sclk_fall) begin
                miso_reg <= tx_reg[g_width-1];
                tx_reg   <= {tx_reg[g_width-2:0], 1'b0};
            end
        end else begin
            miso_reg <= 1'b0;
            if (cmd_done) begin
                tx_reg <= rx_next[7] ? rd_data : '0;
            end
        end
    end

    assign spi_miso_o = miso_reg;
`else
    logic unused_readback;
    assign unused_readback = ^{rd_data, sclk_fall, cmd_done};
    assign spi_miso_o      = 1'b0;
`endif

    assign gpio_o        = out_reg;
    assign gpio_oe_o     = dir_reg;
    assign frame_ok_p_o  = frame_ok_reg;
    assign frame_err_p_o = frame_err_reg;

endmodule
